wb_rr_arbiter: RTL
==================

# wb_rr_arbiter

Two-master, one-slave Wishbone classic arbiter that lets the picorv32 share the system bus path to `wb_ram` with a second master, such as a DMA or debug bridge. Owner selection is round-robin and the grant is held for the whole `cyc` of the owner. A built-in watchdog terminates stalled accesses with `err` so a hung slave cannot lock the CPU. It sits between the masters and the intercon/slave port.

## Interface
Parameters:
- `ADR_W`, 32: address width.
- `DAT_W`, 32: data width; `sel` width is `DAT_W/8`.
- `TIMEOUT_CYCLES`, 255: stalled-strobe limit. 0 disables the watchdog. Legal range 0..65535.

Ports:
- `clk_i`  in  1: clock. All logic is in this single domain.
- `rst_n_i`  in  1: reset. Asynchronous assertion, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each: master 0 (picorv32) control.
- `m0_adr_i`  in  `ADR_W`: master 0 address.
- `m0_dat_i`  in  `DAT_W`: master 0 write data.
- `m0_sel_i`  in  `DAT_W/8`: master 0 byte selects.
- `m0_dat_o`  out  `DAT_W`: read data to master 0.
- `m0_ack_o`, `m0_err_o`  out  1 each: master 0 termination.
- `m1_*`: identical set for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each: slave control.
- `s_adr_o`  out  `ADR_W`: slave address.
- `s_dat_o`  out  `DAT_W`: slave write data.
- `s_sel_o`  out  `DAT_W/8`: slave byte selects.
- `s_dat_i`  in  `DAT_W`: slave read data.
- `s_ack_i`, `s_err_i`  in  1 each: slave termination.
- `grant_o`  out  2: one-hot current owner. 00 means idle.
- `timeout_o`  out  1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states:
  - IDLE. On a clock edge:
    - only `m0_cyc_i` high → GRANT0.
    - only `m1_cyc_i` high → GRANT1.
    - both high → grant the master that was not granted last.
    - neither → stay in IDLE.
  - GRANT0 / GRANT1: stay while the owner's `cyc_i` is high. Go to IDLE on the edge where it is sampled low. There is no direct GRANT0↔GRANT1 handover; one IDLE cycle always separates owners.
- `last` register records the previous owner. Reset value is 1, so m0 wins the first tie.
- The owner's `cyc`/`stb`/`we`/`adr`/`dat`/`sel` are muxed combinationally to `s_*`. In IDLE, all `s_*` outputs are 0.
- `s_dat_i` is broadcast to both `m*_dat_o`.
- `s_ack_i` and `s_err_i` are routed only to the owner. The non-owner sees ack=0 and err=0, even while its own `stb` is high.
- Watchdog:
  - 16-bit counter increments each cycle with `s_stb_o`=1 and `s_ack_i`=`s_err_i`=0.
  - Cleared on ack, on err, when `stb` is low, or in IDLE.
  - When count equals `TIMEOUT_CYCLES` and the slave has not terminated, `owner_err_o`=1 and `timeout_o`=1 for that cycle. Counter clears.
  - If the slave acks in the same cycle the watchdog would fire, the ack wins: no err, no `timeout_o`.
  - `TIMEOUT_CYCLES`=0: counter is held at 0 and never fires.
- Reset mid-transfer: the FSM goes to IDLE immediately, the counter clears, `last`=1, and all outputs drop to 0 asynchronously. An in-flight slave ack is discarded.

## Timing
- Reset values: all `s_*`=0, `m*_ack_o`=`m*_err_o`=0, `grant_o`=00, `timeout_o`=0. `m*_dat_o` follows `s_dat_i`.
- Grant latency: `cyc` rising in cycle N gives `s_cyc_o`=1 and `grant_o` valid in cycle N+1.
- Ack/err path from the slave to the owner is combinational, with zero added latency.
- Release: owner `cyc` low in cycle N → IDLE in N+1. The other master's `s_cyc_o` can be high no earlier than N+2.
- Watchdog fires in the (`TIMEOUT_CYCLES`+1)-th consecutive stalled strobe cycle.
- Back-to-back strobes within one `cyc` stay granted; no arbitration occurs between them.

## Test plan
- Reset then idle: with `rst_n_i`=0, check every output is 0 and `grant_o`=00. Release reset with no requests → everything stays 0.
- Single master: m1 writes 0xDEADBEEF to 0x100 with sel=0xF.
  - `grant_o`=10 one cycle after `cyc`.
  - Slave sees the exact address, data and sel.
  - `m1_ack_o` follows `s_ack_i`; `m0_ack_o` stays 0.
- Simultaneous requests, repeated 4 times with both `cyc` rising together each time (each `cyc` held 3 cycles) → grants go m0, m1, m0, m1, with one IDLE cycle between owners.
- Lock: m0 holds `cyc` for 3 strobes (reads of 0x0, 0x4, 0x8) while m1 requests throughout.
  - m1 is not granted until the cycle after m0 drops `cyc`.
  - `m1_ack_o` stays 0 during m0's strobes.
- Watchdog, with `TIMEOUT_CYCLES`=4:
  - No slave ack → `m0_err_o` and `timeout_o` pulse in the 5th stalled cycle.
  - Repeat with the slave acking in exactly that cycle → ack only, no err.
  - With `TIMEOUT_CYCLES`=0 → never fires over 1000 cycles.
- Reset during an m1 stalled transfer at count 2 → all outputs go to 0 asynchronously. After release, a tie grants m0 first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone classic arbiter. Grants are round-robin and held for the owner's whole cyc.
// A watchdog ends stalled strobes with err so a hung slave cannot lock a master.
module wb_rr_arbiter #(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_n_i,

    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    output logic               m0_ack_o,
    output logic               m0_err_o,

    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    output logic               m1_ack_o,
    output logic               m1_err_o,

    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,

    output logic [1:0]         grant_o,
    output logic               timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);

    state_t      state;
    logic        last;
    logic [15:0] wd_cnt;
    logic        own0, own1;
    logic        stall, wd_fire;

    assign own0    = (state == GRANT0);
    assign own1    = (state == GRANT1);
    assign grant_o = {own1, own0};

    // Owner mux; nothing reaches the slave while idle.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    // A slave ack or err in the limit cycle suppresses the watchdog.
    assign stall     = s_stb_o & ~s_ack_i & ~s_err_i;
    assign wd_fire   = WD_EN && stall && (wd_cnt == WD_LIMIT);
    assign timeout_o = wd_fire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = own0 & s_ack_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m0_err_o = own0 & (s_err_i | wd_fire);
    assign m1_err_o = own1 & (s_err_i | wd_fire);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // last==1 means m1 owned most recently, so m0 wins a tie.
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= GRANT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= GRANT1;
                        last  <= 1'b1;
                    end
                end
                GRANT0:  if (!m0_cyc_i) state <= IDLE;
                GRANT1:  if (!m1_cyc_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            wd_cnt <= '0;
        else if (!WD_EN || !stall || wd_fire)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end

endmodule
